// File: rtl/aes_tcdm_bank_mem.sv
// Word-interleaved multi-bank TCDM responder: per-bank round-robin arbitration,
// combinational grant and a registered response exactly one cycle later.
module aes_tcdm_bank_mem #(
  parameter int unsigned MP         = 2,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_DEPTH = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  output logic [31:0]          conflict_cnt_o
);

  localparam int unsigned LOG_NB = $clog2(NB_BANKS);
  localparam int unsigned BANK_W = (LOG_NB > 0) ? LOG_NB : 1;
  localparam int unsigned ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int unsigned PTR_W  = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned CNT_W  = $clog2(MP + 1);

  logic [31:0] mem [NB_BANKS][BANK_DEPTH];

  logic [MP-1:0][BANK_W-1:0]       port_bank;
  logic [MP-1:0][ROW_W-1:0]        port_row;
  logic [NB_BANKS-1:0][PTR_W-1:0]  rr_ptr;
  logic [NB_BANKS-1:0][PTR_W-1:0]  win_port;
  logic [NB_BANKS-1:0]             win_valid;
  logic [NB_BANKS-1:0]             bank_gnt;
  logic                            allow;
  logic [CNT_W-1:0]                deny_n;
  logic [32:0]                     cnt_sum;
  logic                            unused_add;

  // Upper address bits beyond bank+row select are intentionally ignored (wrap).
  assign unused_add = ^tcdm_add_i;
  assign allow      = ~stall_i & ~rst_i;

  // Address split: word-interleaved bank select, then row.
  always_comb begin
    port_bank = '0;
    port_row  = '0;
    for (int p = 0; p < int'(MP); p++) begin
      port_bank[p] = tcdm_add_i[p][2 +: BANK_W] & BANK_W'(NB_BANKS - 1);
      port_row[p]  = tcdm_add_i[p][2 + LOG_NB +: ROW_W];
    end
  end

  // Round-robin: first search from rr_ptr upwards, then wrap to the low ports.
  always_comb begin
    win_valid = '0;
    win_port  = '0;
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      for (int p = 0; p < int'(MP); p++) begin
        if (!win_valid[b] && tcdm_req_i[p] && port_bank[p] == BANK_W'(b) &&
            p >= int'(32'(rr_ptr[b]))) begin
          win_valid[b] = 1'b1;
          win_port[b]  = PTR_W'(p);
        end
      end
      for (int p = 0; p < int'(MP); p++) begin
        if (!win_valid[b] && tcdm_req_i[p] && port_bank[p] == BANK_W'(b) &&
            p < int'(32'(rr_ptr[b]))) begin
          win_valid[b] = 1'b1;
          win_port[b]  = PTR_W'(p);
        end
      end
    end
  end

  always_comb begin
    tcdm_gnt_o = '0;
    bank_gnt   = '0;
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      bank_gnt[b] = allow & win_valid[b];
    end
    for (int p = 0; p < int'(MP); p++) begin
      tcdm_gnt_o[p] = allow & tcdm_req_i[p] & win_valid[port_bank[p]] &
                      (win_port[port_bank[p]] == PTR_W'(p));
    end
  end

  // Denied requests this cycle, including stall-induced denials.
  always_comb begin
    deny_n = '0;
    for (int p = 0; p < int'(MP); p++) begin
      deny_n = deny_n + CNT_W'(tcdm_req_i[p] & ~tcdm_gnt_o[p]);
    end
    cnt_sum = {1'b0, conflict_cnt_o} + 33'(deny_n);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcdm_r_valid_o <= '0;
      tcdm_r_data_o  <= '0;
      conflict_cnt_o <= '0;
      rr_ptr         <= '0;
    end else begin
      tcdm_r_valid_o <= tcdm_gnt_o;
      for (int p = 0; p < int'(MP); p++) begin
        tcdm_r_data_o[p] <= (tcdm_gnt_o[p] & tcdm_wen_i[p]) ?
                            mem[port_bank[p]][port_row[p]] : 32'h0;
      end
      conflict_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      for (int b = 0; b < int'(NB_BANKS); b++) begin
        if (bank_gnt[b]) begin
          rr_ptr[b] <= (win_port[b] == PTR_W'(MP - 1)) ? '0 : PTR_W'(win_port[b] + 1'b1);
        end
      end
    end
  end

  // Storage is not reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      if (bank_gnt[b] && !tcdm_wen_i[win_port[b]]) begin
        for (int i = 0; i < 4; i++) begin
          if (tcdm_be_i[win_port[b]][i]) begin
            mem[b][port_row[win_port[b]]][8*i +: 8] <= tcdm_data_i[win_port[b]][8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_tcdm_bank_mem.sv
// Directed bench for aes_tcdm_bank_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares them against r_valid/r_data.
module tb_aes_tcdm_bank_mem;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [1:0]       req, gnt, wen, r_valid;
  logic [1:0][31:0] add, data, r_data;
  logic [1:0][3:0]  be;
  logic [31:0]      cnt;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q [2][$];

  aes_tcdm_bank_mem #(.MP(2), .NB_BANKS(4), .BANK_DEPTH(1024)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (data),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic [31:0] a,
                          input logic w, input logic [3:0] b, input logic [31:0] d);
    req[p]  = r;
    add[p]  = a;
    wen[p]  = w;
    be[p]   = b;
    data[p] = d;
  endtask

  task automatic idle_ports();
    set_port(0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
    set_port(1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
  endtask

  // Called at posedge+2 with inputs set; checks grant, queues responses, moves on.
  task automatic step(input string nm, input logic [1:0] eg,
                      input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    #1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    for (int p = 0; p < 2; p++) begin
      if (eg[p]) begin
        e.data = (p == 0) ? e0 : e1;
        e.cyc  = cyc + 1;
        exp_q[p].push_back(e);
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input string nm);
    idle_ports();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk({nm, "_rvalid"}, 32'(r_valid), 32'h0);
    chk({nm, "_cnt"}, cnt, 32'h0);
  endtask

  // Response monitor: every r_valid must match the oldest expected entry and cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (r_valid[p] === 1'b1) begin
        total++;
        if (exp_q[p].size() == 0) begin
          bad++;
          $display("FAIL resp_p%0d: unexpected r_valid data %h at cycle %0d", p, r_data[p], cyc);
        end else begin
          e = exp_q[p].pop_front();
          if (r_data[p] !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL resp_p%0d: got %h at cycle %0d want %h at cycle %0d",
                     p, r_data[p], cyc, e.data, e.cyc);
          end
        end
      end else if (exp_q[p].size() != 0 && exp_q[p][0].cyc <= cyc) begin
        total++;
        bad++;
        e = exp_q[p].pop_front();
        $display("FAIL resp_p%0d: missing r_valid at cycle %0d want %h", p, cyc, e.data);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    idle_ports();
    set_port(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
    @(posedge clk);
    #2;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rvalid", 32'(r_valid), 32'h0);
    chk("reset_cnt", cnt, 32'h0);
    rst = 1'b0;
    idle_ports();
    @(posedge clk);
    #2;

    // Write then read back on port 0.
    set_port(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    step("wr_dead", 2'b01, 32'h0, 32'h0);
    set_port(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
    step("rd_dead", 2'b01, 32'hDEADBEEF, 32'h0);
    idle_ports();

    // Byte enables on port 1.
    set_port(1, 1'b1, 32'h20, 1'b0, 4'hF, 32'h11223344);
    step("wr_full", 2'b10, 32'h0, 32'h0);
    set_port(1, 1'b1, 32'h20, 1'b0, 4'b0101, 32'hAABBCCDD);
    step("wr_be", 2'b10, 32'h0, 32'h0);
    set_port(1, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0);
    step("rd_be", 2'b10, 32'h0, 32'h11BB33DD);
    idle_ports();

    // Address wrap: 0x4000 aliases 0x0000.
    set_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h5A5A5A5A);
    step("wr_wrap", 2'b01, 32'h0, 32'h0);
    set_port(0, 1'b1, 32'h4000, 1'b1, 4'h0, 32'h0);
    step("rd_wrap", 2'b01, 32'h5A5A5A5A, 32'h0);
    idle_ports();

    // Same-bank conflict from reset: alternating grants.
    do_reset("rst1");
    set_port(0, 1'b1, 32'h00, 1'b1, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
    step("conf_c1", 2'b01, 32'h5A5A5A5A, 32'h0);
    step("conf_c2", 2'b10, 32'h0, 32'hDEADBEEF);
    step("conf_c3", 2'b01, 32'h5A5A5A5A, 32'h0);
    step("conf_c4", 2'b10, 32'h0, 32'hDEADBEEF);
    idle_ports();
    chk("conf_cnt", cnt, 32'd4);

    // Different banks: both granted, counter unchanged.
    set_port(0, 1'b1, 32'h00, 1'b1, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h04, 1'b0, 4'hF, 32'h0BADF00D);
    step("par_wr", 2'b11, 32'h5A5A5A5A, 32'h0);
    set_port(1, 1'b1, 32'h04, 1'b1, 4'h0, 32'h0);
    step("par_rd", 2'b11, 32'h5A5A5A5A, 32'h0BADF00D);
    idle_ports();
    chk("par_cnt", cnt, 32'd4);

    // Stall backpressure then reset keeps memory.
    do_reset("rst2");
    stall = 1'b1;
    set_port(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
    step("stall_c1", 2'b00, 32'h0, 32'h0);
    step("stall_c2", 2'b00, 32'h0, 32'h0);
    step("stall_c3", 2'b00, 32'h0, 32'h0);
    stall = 1'b0;
    step("stall_c4", 2'b01, 32'hDEADBEEF, 32'h0);
    idle_ports();
    chk("stall_cnt", cnt, 32'd3);
    do_reset("rst3");
    set_port(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
    step("retain_rd", 2'b01, 32'hDEADBEEF, 32'h0);
    idle_ports();

    // Drain outstanding responses.
    step("drain1", 2'b00, 32'h0, 32'h0);
    step("drain2", 2'b00, 32'h0, 32'h0);
    chk("q0_empty", 32'(exp_q[0].size()), 32'h0);
    chk("q1_empty", 32'(exp_q[1].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
